instruction_fetch_unit: RTL

// - Fetch-stage initiator for the pipelined CPU. Owns the PC and drives instructionAddress into

---
 rtl/instruction_fetch_unit_pkg.sv | 17 +
 rtl/instruction_fetch_unit_ifid_register.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 76 +++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: word width, default encodings and the IF/ID payload.
package instruction_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP_DEF   = 32'd4;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } ifid_t;

endpackage

// File: rtl/instruction_fetch_unit_ifid_register.sv
// IF/ID pipeline register. A bubble load wins over hold; a bubble keeps the
// previous pc/pcplus4 and only replaces the instruction and clears valid.
module ifid_register
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  hold,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q.instr   <= NOP_INSTR;
      q.pc      <= '0;
      q.pcplus4 <= '0;
      q.valid   <= 1'b0;
    end else if (bubble) begin
      q.instr   <= NOP_INSTR;
      q.valid   <= 1'b0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, next-PC selection and the IF/ID capture.
// Priority per edge: RST > branchTaken > stall > normal.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] PC_STEP   = PC_STEP_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  output logic [XLEN-1:0] instructionAddress,
  input  logic [XLEN-1:0] instruction,
  input  logic            stall,
  input  logic            flush,
  input  logic            branchTaken,
  input  logic [XLEN-1:0] branchTarget,
  output logic [XLEN-1:0] ifidInstruction,
  output logic [XLEN-1:0] ifidPC,
  output logic [XLEN-1:0] ifidPCPlus4,
  output logic            ifidValid,
  output logic            misalignedTarget
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_seq;
  logic            ifid_hold;
  logic            ifid_bubble;
  ifid_t           ifid_d;
  ifid_t           ifid_q;

  assign pc_seq = pc + PC_STEP;

  // A taken redirect squashes whatever sits in IF/ID, even a stalled entry.
  assign ifid_bubble = branchTaken | flush;
  assign ifid_hold   = stall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc               <= RESET_PC;
      misalignedTarget <= 1'b0;
    end else begin
      misalignedTarget <= branchTaken & (|branchTarget[1:0]);
      if (branchTaken)
        pc <= {branchTarget[XLEN-1:2], 2'b00};
      else if (!stall)
        pc <= pc_seq;
    end
  end

  always_comb begin
    ifid_d         = '0;
    ifid_d.instr   = instruction;
    ifid_d.pc      = pc;
    ifid_d.pcplus4 = pc_seq;
    ifid_d.valid   = 1'b1;
  end

  ifid_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid (
    .clk    (CLK),
    .rst    (RST),
    .hold   (ifid_hold),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign instructionAddress = pc;
  assign ifidInstruction    = ifid_q.instr;
  assign ifidPC             = ifid_q.pc;
  assign ifidPCPlus4        = ifid_q.pcplus4;
  assign ifidValid          = ifid_q.valid;

endmodule
